// File: rtl/ti_adc_capture.sv
// Time-interleaved ADC capture: register raw sub-ADC codes, remove mid-scale and per-way offset
// with saturation, then buffer tagged frames in a first-word-fall-through FIFO with drop accounting.
module ti_adc_capture #(
    parameter int WAYS  = 8,
    parameter int BITS  = 9,
    parameter int DEPTH = 4
) (
    input  logic                   CLKOUT_DES,
    input  logic                   RSTN,
    input  logic [BITS-1:0]        ADCOUT0,
    input  logic [BITS-1:0]        ADCOUT1,
    input  logic [BITS-1:0]        ADCOUT2,
    input  logic [BITS-1:0]        ADCOUT3,
    input  logic [BITS-1:0]        ADCOUT4,
    input  logic [BITS-1:0]        ADCOUT5,
    input  logic [BITS-1:0]        ADCOUT6,
    input  logic [BITS-1:0]        ADCOUT7,
    input  logic                   EN,
    input  logic [WAYS*BITS-1:0]   OFS,
    output logic [WAYS*BITS-1:0]   OUT_DATA,
    output logic [15:0]            OUT_FCNT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OVF,
    input  logic                   CLR_OVF,
    output logic [7:0]             DROP_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = BITS + 2;
    localparam logic signed [CW-1:0] C_HI  = CW'((2 ** (BITS - 1)) - 1);
    localparam logic signed [CW-1:0] C_LO  = ~C_HI;
    localparam logic signed [CW-1:0] C_MID = CW'(2 ** (BITS - 1));

    logic [BITS-1:0]      w_adc [8];
    logic [BITS-1:0]      r_s1 [WAYS];
    logic                 r_s1_valid;
    logic [WAYS*BITS-1:0] w_corr;
    logic [WAYS*BITS-1:0] r_s2;
    logic                 r_s2_valid;

    logic [WAYS*BITS-1:0] r_mem_data [DEPTH];
    logic [15:0]          r_mem_tag [DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [15:0]          r_fcnt;
    logic                 r_ovf;
    logic [7:0]           r_drop_cnt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    assign w_adc[0] = ADCOUT0;
    assign w_adc[1] = ADCOUT1;
    assign w_adc[2] = ADCOUT2;
    assign w_adc[3] = ADCOUT3;
    assign w_adc[4] = ADCOUT4;
    assign w_adc[5] = ADCOUT5;
    assign w_adc[6] = ADCOUT6;
    assign w_adc[7] = ADCOUT7;

    // Two guard bits keep (code - midscale - offset) exact before clamping.
    function automatic logic [BITS-1:0] f_corr(input logic [BITS-1:0] code,
                                               input logic [BITS-1:0] ofs);
        logic signed [CW-1:0] v_diff;
        v_diff = $signed({2'b00, code}) - C_MID - $signed({{2{ofs[BITS-1]}}, ofs});
        if (v_diff > C_HI)
            v_diff = C_HI;
        else if (v_diff < C_LO)
            v_diff = C_LO;
        return BITS'(v_diff);
    endfunction

    always_comb begin
        w_corr = '0;
        for (int i = 0; i < WAYS; i++)
            w_corr[BITS*i +: BITS] = f_corr(r_s1[i], OFS[BITS*i +: BITS]);
    end

    always_ff @(posedge CLKOUT_DES) begin
        for (int i = 0; i < WAYS; i++)
            r_s1[i] <= w_adc[i];
        r_s2 <= w_corr;
        if (!RSTN) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= EN;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && OUT_READY;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_push  = r_s2_valid && (!w_full || w_pop);
    assign w_drop  = r_s2_valid && w_full && !w_pop;

    always_ff @(posedge CLKOUT_DES) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= r_s2;
            r_mem_tag[r_wr_ptr[AW-1:0]]  <= r_fcnt;
        end
    end

    always_ff @(posedge CLKOUT_DES) begin
        if (!RSTN) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fcnt     <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                r_fcnt   <= r_fcnt + 16'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            // A drop coinciding with a clear counts as the first drop after the clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (CLR_OVF)
                    r_drop_cnt <= 8'd1;
                else if (r_drop_cnt != 8'hFF)
                    r_drop_cnt <= r_drop_cnt + 8'd1;
            end else if (CLR_OVF) begin
                r_ovf      <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign OUT_VALID = !w_empty;
    assign OUT_DATA  = w_empty ? '0 : r_mem_data[r_rd_ptr[AW-1:0]];
    assign OUT_FCNT  = w_empty ? '0 : r_mem_tag[r_rd_ptr[AW-1:0]];
    assign OVF       = r_ovf;
    assign DROP_CNT  = r_drop_cnt;

endmodule
